// File: rtl/spi_pkg.sv
// Shared command codes, FSM state type and framing helper for the SPI SRAM master.
package spi_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE,
    GAP
  } spi_state_t;

  function automatic logic [7:0] spi_cmd(input logic we);
    return we ? SPI_CMD_WRITE : SPI_CMD_READ;
  endfunction

endpackage

// File: rtl/spi_mem_master_if.sv
// CPU-side request/acknowledge port of the SPI SRAM master.
interface spi_mem_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              ack_o;
  logic [DATA_W-1:0] rdata_o;
  logic              busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, busy_o
  );

endinterface

// File: rtl/spi_mem_master_clk_gen.sv
// SCLK generator: CLK_DIV cycles per half-period, idles low whenever disabled.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int PH_W = $clog2(CLK_DIV + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] phase_cnt;
  logic            half_end;

  // Strobes flag the cycle whose closing edge toggles sclk_o.
  assign half_end = en && (phase_cnt == PH_LAST);
  assign rise_o   = half_end && !sclk_o;
  assign fall_o   = half_end && sclk_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
      sclk_o    <= 1'b0;
    end else if (!en) begin
      phase_cnt <= '0;
      sclk_o    <= 1'b0;
    end else if (half_end) begin
      phase_cnt <= '0;
      sclk_o    <= ~sclk_o;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_master.sv
// SPI mode-0 master turning single-word CPU requests into 23LC-style READ/WRITE frames.
module spi_mem_master
  import spi_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic               clk,
  input  logic               reset,
  spi_mem_master_if.slave    bus,
  output logic               sclk_o,
  output logic               csb_o,
  output logic               mo_o,
  input  logic               mi_i
);

  localparam int N        = 8 + ADDR_W + DATA_W;
  localparam int RX_START = 8 + ADDR_W;
  localparam int BIT_W    = $clog2(N + 1);
  localparam int PH_W     = $clog2(CLK_DIV + 1);
  localparam int GAP_W    = (CS_GAP < 1) ? 1 : $clog2(CS_GAP + 1);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(N - 1);
  localparam logic [BIT_W-1:0] RX_FIRST  = BIT_W'(RX_START);
  localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  if ((ADDR_W < 8) || (ADDR_W > 32) || (ADDR_W % 8 != 0)) begin : g_bad_addr_w
    $error("spi_mem_master: ADDR_W must be a multiple of 8 in 8..32");
  end
  if ((DATA_W < 8) || (DATA_W > 32) || (DATA_W % 8 != 0)) begin : g_bad_data_w
    $error("spi_mem_master: DATA_W must be a multiple of 8 in 8..32");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_mem_master: CLK_DIV must be at least 1");
  end
  if (CS_GAP < 0) begin : g_bad_cs_gap
    $error("spi_mem_master: CS_GAP must not be negative");
  end

  spi_state_t        state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [PH_W-1:0]   hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              we_q;
  logic [N-1:0]      frame;
  logic [N-1:0]      tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              shift_en;
  logic              accept;
  logic              sclk_rise;
  logic              sclk_fall;

  assign shift_en = (state == SHIFT);
  assign accept   = (state == IDLE) && bus.req_i;
  assign frame    = {spi_cmd(bus.we_i), bus.addr_i, bus.we_i ? bus.wdata_i : DATA_W'(0)};

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (shift_en),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall),
    .sclk_o (sclk_o)
  );

  // Control FSM; every pad and handshake output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      csb_o       <= 1'b1;
      mo_o        <= 1'b0;
      bus.ack_o   <= 1'b0;
      bus.busy_o  <= 1'b0;
      bus.rdata_o <= '0;
      bit_cnt     <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      we_q        <= 1'b0;
    end else begin
      bus.ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            state      <= SHIFT;
            csb_o      <= 1'b0;
            mo_o       <= frame[N-1];
            bus.busy_o <= 1'b1;
            we_q       <= bus.we_i;
            bit_cnt    <= '0;
          end
        end
        SHIFT: begin
          // The falling SCLK edge closes one bit and presents the next.
          if (sclk_fall) begin
            if (bit_cnt == BIT_LAST) begin
              state    <= HOLD;
              mo_o     <= 1'b0;
              hold_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              mo_o    <= tx_sh[N-1];
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= DONE;
            csb_o     <= 1'b1;
            mo_o      <= 1'b0;
            bus.ack_o <= 1'b1;
            if (!we_q) begin
              bus.rdata_o <= rx_sh;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          if (CS_GAP == 0) begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end else begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Shift registers carry data only; the FSM decides when their contents matter.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sh <= {frame[N-2:0], 1'b0};
    end else if (shift_en && sclk_fall) begin
      tx_sh <= {tx_sh[N-2:0], 1'b0};
    end
    if (shift_en && sclk_rise && (bit_cnt >= RX_FIRST)) begin
      rx_sh <= {rx_sh[DATA_W-2:0], mi_i};
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: directed and randomized frames against an SPI SRAM model.
`timescale 1ns/1ps

module tb_spi_mem_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Instance A: default parameters
  spi_mem_master_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
  logic sclk_a, csb_a, mo_a, mi_a;

  spi_mem_master #(.ADDR_W(16), .DATA_W(16), .CLK_DIV(2), .CS_GAP(2)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .bus    (ifa),
    .sclk_o (sclk_a),
    .csb_o  (csb_a),
    .mo_o   (mo_a),
    .mi_i   (mi_a)
  );

  // Instance B: parameter sweep point
  spi_mem_master_if #(.ADDR_W(24), .DATA_W(8)) ifb ();
  logic sclk_b, csb_b, mo_b, mi_b;

  spi_mem_master #(.ADDR_W(24), .DATA_W(8), .CLK_DIV(1), .CS_GAP(0)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .bus    (ifb),
    .sclk_o (sclk_b),
    .csb_o  (csb_b),
    .mo_o   (mo_b),
    .mi_i   (mi_b)
  );

  // SPI SRAM model for A: captures mo on SCLK rise, drives mi on SCLK fall.
  logic [15:0] dev_mem_a [logic [15:0]];
  logic [15:0] ref_mem   [logic [15:0]];
  logic [39:0] cap_a, frame_a;
  logic [15:0] dev_addr_a, rd_w_a;
  int          rises_a = 0;
  int          bits_a  = 0;

  function automatic logic [15:0] dev_rd(input logic [15:0] a);
    return dev_mem_a.exists(a) ? dev_mem_a[a] : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
  endfunction

  always @(negedge csb_a or posedge sclk_a) begin
    if (!csb_a && sclk_a) begin
      cap_a = {cap_a[38:0], mo_a};
      rises_a++;
      if (rises_a == 24) dev_addr_a = cap_a[15:0];
    end else if (!csb_a) begin
      rises_a = 0;
    end
  end

  always @(posedge csb_a) begin
    frame_a = cap_a;
    bits_a  = rises_a;
    if (rises_a == 40 && cap_a[39:32] == 8'h02) dev_mem_a[cap_a[31:16]] = cap_a[15:0];
  end

  always @(negedge sclk_a or negedge csb_a) begin
    if (!csb_a && rises_a >= 24 && rises_a < 40) begin
      rd_w_a = dev_rd(dev_addr_a);
      mi_a   = rd_w_a[39 - rises_a];
    end else begin
      mi_a = 1'b0;
    end
  end

  // SPI SRAM model for B: always answers with resp_b.
  logic [39:0] cap_b, frame_b;
  logic [7:0]  resp_b = 8'h5A;
  int          rises_b = 0;
  int          bits_b  = 0;

  always @(negedge csb_b or posedge sclk_b) begin
    if (!csb_b && sclk_b) begin
      cap_b = {cap_b[38:0], mo_b};
      rises_b++;
    end else if (!csb_b) begin
      rises_b = 0;
    end
  end

  always @(posedge csb_b) begin
    frame_b = cap_b;
    bits_b  = rises_b;
  end

  always @(negedge sclk_b or negedge csb_b) begin
    if (!csb_b && rises_b >= 32 && rises_b < 40) mi_b = resp_b[39 - rises_b];
    else mi_b = 1'b0;
  end

  logic [15:0] last_rd = '0;

  // One frame on A: accept edge ends cycle 0, then cycle c is sampled at its negedge.
  task automatic txn_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input int glitch_cyc, output int ack_cyc, output int csb_low,
                       output int acks, output int busy_fall);
    int c;
    @(negedge clk);
    ifa.req_i = 1'b1; ifa.we_i = we; ifa.addr_i = addr; ifa.wdata_i = wdata;
    @(posedge clk);
    c = 0; ack_cyc = -1; csb_low = 0; acks = 0; busy_fall = -1;
    while (c < 1000 && busy_fall < 0) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        chk("first_csb", csb_a, 1'b0);
        chk("first_busy", ifa.busy_o, 1'b1);
        chk("first_mo_cmd_msb", mo_a, 1'b0);
        if (glitch_cyc > 0) ifa.req_i = 1'b0;
      end
      if (glitch_cyc > 0 && c == glitch_cyc) begin
        ifa.req_i = 1'b1; ifa.we_i = ~we; ifa.addr_i = ~addr; ifa.wdata_i = ~wdata;
      end
      if (glitch_cyc > 0 && c == glitch_cyc + 1) ifa.req_i = 1'b0;
      if (!csb_a) csb_low++;
      if (ifa.ack_o) begin acks++; ack_cyc = c; ifa.req_i = 1'b0; end
      if (!ifa.busy_o && ack_cyc >= 0 && busy_fall < 0) busy_fall = c;
    end
    chk("txn_timeout", (c < 1000), 1'b1);
  endtask

  task automatic expect_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input int glitch_cyc);
    int ack_cyc, csb_low, acks, busy_fall;
    logic [39:0] exp_frame;
    exp_frame = {(we ? 8'h02 : 8'h03), addr, (we ? wdata : 16'h0000)};
    txn_a(we, addr, wdata, glitch_cyc, ack_cyc, csb_low, acks, busy_fall);
    chk("ack_cycle", ack_cyc, 163);
    chk("csb_low_cycles", csb_low, 162);
    chk("ack_count", acks, 1);
    chk("busy_fall", busy_fall, ack_cyc + 3);
    chk("frame_bits", bits_a, 40);
    chk("mo_frame", frame_a, exp_frame);
    chk("rdata", ifa.rdata_o, last_rd);
  endtask

  initial begin
    int c, n, ack1, ack2, hi_after, busy_low, nacks;
    int ack_b, low_b, bf_b, r1, r2, nack_b;
    logic prev_s, seen_ack1, we;
    logic [15:0] addr, wdata;

    reset = 1'b1;
    ifa.req_i = 1'b0; ifa.we_i = 1'b0; ifa.addr_i = '0; ifa.wdata_i = '0;
    ifb.req_i = 1'b0; ifb.we_i = 1'b0; ifb.addr_i = '0; ifb.wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_csb", csb_a, 1'b1);
    chk("rst_sclk", sclk_a, 1'b0);
    chk("rst_mo", mo_a, 1'b0);
    chk("rst_ack", ifa.ack_o, 1'b0);
    chk("rst_busy", ifa.busy_o, 1'b0);
    chk("rst_rdata", ifa.rdata_o, 16'h0000);
    chk("rst_b_csb", csb_b, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed read and write at default parameters
    dev_mem_a[16'h1234] = 16'hBEEF; ref_mem[16'h1234] = 16'hBEEF;
    last_rd = 16'hBEEF;
    expect_txn(1'b0, 16'h1234, 16'h0000, 0);
    ref_mem[16'h00FF] = 16'hA5C3;
    expect_txn(1'b1, 16'h00FF, 16'hA5C3, 0);
    chk("wr_model_mem", dev_rd(16'h00FF), 16'hA5C3);

    // Back-to-back reads with req held high
    @(negedge clk);
    ifa.req_i = 1'b1; ifa.we_i = 1'b0; ifa.addr_i = 16'h1234;
    @(posedge clk);
    c = 0; ack1 = -1; ack2 = -1; hi_after = 0; busy_low = -1; nacks = 0; seen_ack1 = 1'b0;
    while (c < 2000 && ack2 < 0) begin
      @(negedge clk);
      c++;
      if (seen_ack1 && ack2 < 0 && busy_low >= 0 && csb_a) hi_after = hi_after;
      if (seen_ack1 && busy_low < 0 && !ifa.busy_o) busy_low = c;
      if (seen_ack1 && c > ack1 && csb_a && hi_after >= 0 && !(c > ack1 + hi_after + 1)) hi_after++;
      if (ifa.ack_o) begin
        nacks++;
        if (!seen_ack1) begin ack1 = c; seen_ack1 = 1'b1; end
        else begin ack2 = c; ifa.req_i = 1'b0; end
      end
    end
    chk("b2b_timeout", (c < 2000), 1'b1);
    chk("b2b_csb_high_after_ack", hi_after, 3);
    chk("b2b_busy_fall", busy_low, ack1 + 3);
    chk("b2b_second_ack", ack2, busy_low + 163);
    chk("b2b_ack_count", nacks, 2);
    chk("b2b_rdata", ifa.rdata_o, 16'hBEEF);
    repeat (10) @(negedge clk);
    chk("b2b_idle_after", {csb_a, ifa.busy_o}, 2'b10);

    // Request pulse with other addr/we while busy is ignored
    ref_mem[16'h0F0F] = 16'h1357;
    expect_txn(1'b1, 16'h0F0F, 16'h1357, 50);
    chk("glitch_no_stray_write", dev_mem_a.exists(16'hF0F0), 1'b0);

    // Reset at the start of bit 20 of a read
    @(negedge clk);
    ifa.req_i = 1'b1; ifa.we_i = 1'b0; ifa.addr_i = 16'h2222;
    @(posedge clk);
    repeat (81) @(negedge clk);
    chk("rst_mid_pre_csb", csb_a, 1'b0);
    reset = 1'b1; ifa.req_i = 1'b0;
    #1;
    chk("rst_mid_csb", csb_a, 1'b1);
    chk("rst_mid_sclk", sclk_a, 1'b0);
    chk("rst_mid_busy", ifa.busy_o, 1'b0);
    chk("rst_mid_rdata", ifa.rdata_o, 16'h0000);
    chk("rst_mid_bits", bits_a, 20);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (ifa.ack_o || !csb_a) n++;
    end
    chk("rst_mid_no_ack", n, 0);
    last_rd = ref_rd(16'h2222);
    expect_txn(1'b0, 16'h2222, 16'h0000, 0);

    // Randomized reads and writes over a small address pool
    for (int i = 0; i < 8; i++) begin
      we    = 1'($urandom_range(0, 1));
      addr  = {8'h40, 6'd0, 2'($urandom_range(0, 3))};
      wdata = 16'($urandom);
      if (we) ref_mem[addr] = wdata;
      else last_rd = ref_rd(addr);
      expect_txn(we, addr, wdata, 0);
    end

    // Parameter sweep instance: ADDR_W=24, DATA_W=8, CLK_DIV=1, CS_GAP=0
    @(negedge clk);
    ifb.req_i = 1'b1; ifb.we_i = 1'b0; ifb.addr_i = 24'hABCDEF; ifb.wdata_i = 8'h00;
    @(posedge clk);
    c = 0; ack_b = -1; low_b = 0; bf_b = -1; r1 = -1; r2 = -1; nack_b = 0; prev_s = 1'b0;
    while (c < 500 && bf_b < 0) begin
      @(negedge clk);
      c++;
      if (sclk_b && !prev_s) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      prev_s = sclk_b;
      if (!csb_b) low_b++;
      if (ifb.ack_o) begin nack_b++; ack_b = c; ifb.req_i = 1'b0; end
      if (!ifb.busy_o && ack_b >= 0 && bf_b < 0) bf_b = c;
    end
    chk("sweep_timeout", (c < 500), 1'b1);
    chk("sweep_first_rise", r1, 2);
    chk("sweep_sclk_period", r2 - r1, 2);
    chk("sweep_ack_cycle", ack_b, 82);
    chk("sweep_csb_low", low_b, 81);
    chk("sweep_busy_fall", bf_b, 83);
    chk("sweep_ack_count", nack_b, 1);
    chk("sweep_bits", bits_b, 40);
    chk("sweep_frame", frame_b, {8'h03, 24'hABCDEF, 8'h00});
    chk("sweep_rdata", ifb.rdata_o, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/spi_mem_master.md
# spi_mem_master

Parametrised SPI master that turns single-word read/write requests from the CPU core into SPI SRAM transactions (mode 0, MSB first, 23LC-style READ 0x03 / WRITE 0x02 framing). It is the generalised successor of the fixed-width SPI master path on the CPU top pins: address width, data width, SCLK rate and inter-transaction gap are parameters, and a request/ack handshake replaces hard-wired fetch sequencing. It sits between the CPU memory port and the `sclk_o`/`csb_o`/`mo_o`/`mi_i` pads.

## Interface
- `ADDR_W`, 16: address bits shifted out; multiple of 8, range 8..32.
- `DATA_W`, 16: data bits per transaction; multiple of 8, range 8..32.
- `CLK_DIV`, 2: system cycles per SCLK half-period; at least 1.
- `CS_GAP`, 2: extra cycles with `csb_o` high after each transaction before the next request is accepted; at least 0.

- `clk` in 1: system clock. Single clock domain; all logic is on its rising edge.
- `reset` in 1: asynchronous reset, active-high.
- `req_i` in 1: transaction request (level).
- `we_i` in 1: 1 = write, 0 = read; sampled at accept.
- `addr_i` in ADDR_W: word address; sampled at accept.
- `wdata_i` in DATA_W: write data; sampled at accept.
- `ack_o` out 1: one-cycle completion pulse.
- `rdata_o` out DATA_W: last read data; held until the next read ack.
- `busy_o` out 1: high from accept+1 through the end of GAP.
- `sclk_o` out 1: SPI clock, idles low.
- `csb_o` out 1: chip select, active-low.
- `mo_o` out 1: master out.
- `mi_i` in 1: master in.

## Operation
- Reset values: `csb_o`=1, `sclk_o`=0, `mo_o`=0, `ack_o`=0, `busy_o`=0, `rdata_o`=0, state IDLE.
- States:
  - IDLE: accept when `req_i`=1, go to SHIFT.
  - SHIFT: N = 8+ADDR_W+DATA_W bits.
  - HOLD: CLK_DIV cycles.
  - DONE: 1 cycle.
  - GAP: CS_GAP cycles.
  - Then back to IDLE.
- Accept: in IDLE with `req_i`=1, latch `we_i`/`addr_i`/`wdata_i` and build the shift word {cmd, addr, data-or-zero}. cmd = 0x02 if write, else 0x03.
- Not-accepted requests are never queued. Requester drops `req_i` in the ack cycle; if `req_i` is still high when IDLE is re-entered, a new transaction starts.
- SHIFT, per bit:
  - `sclk_o` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `mo_o` is updated only while `sclk_o` is low, at the start of the low phase.
  - `mi_i` is sampled on the clock edge that drives `sclk_o` 0→1.
  - Only the final DATA_W samples enter the read shift register.
- Read: `mo_o`=0 during data bits. Write: `mo_o` carries `wdata` MSB first.
- HOLD: `sclk_o`=0, `csb_o`=0.
- DONE:
  - `csb_o`=1, `ack_o`=1, `mo_o`=0.
  - On a read, `rdata_o` takes the assembled word in this cycle; on a write it is unchanged.
  - `busy_o` stays high.

## Timing
- Accept at cycle 0. `csb_o` falls and the cmd MSB is on `mo_o` at cycle 1. First `sclk_o` rise is at cycle 1+CLK_DIV.
- `csb_o` is low for exactly 2·CLK_DIV·N + CLK_DIV cycles.
- `ack_o` is at cycle 1 + 2·CLK_DIV·N + CLK_DIV. Defaults: N=40, ack at cycle 163.
- `busy_o` falls CS_GAP+1 cycles after the ack cycle. The next accept is possible in that same cycle, at the earliest.
- Reset asserted mid-transaction:
  - Outputs go to reset values immediately (async): `csb_o` high, `sclk_o` low.
  - No ack; `rdata_o` is cleared.
- Counters:
  - Bit counter width $clog2(N+1).
  - Phase counter width $clog2(CLK_DIV+1), minimum 1 bit.
  - Gap counter width $clog2(CS_GAP+1), minimum 1 bit.
- Elaboration fails (`$error`) on illegal parameters.

## Structure
- Package `spi_pkg`:
  - `SPI_CMD_READ`=8'h03, `SPI_CMD_WRITE`=8'h02.
  - `spi_state_t` enum {IDLE, SHIFT, HOLD, DONE, GAP}.
- Sub-module `spi_clk_gen`:
  - Counts CLK_DIV, emits one-cycle `rise_o`/`fall_o` strobes and the registered `sclk_o`.
  - Enabled only in SHIFT; cleared on `reset` and on leaving SHIFT.
- Top: FSM, N-bit TX shift register, DATA_W RX shift register, bit and gap counters.

## Test plan
- Read, defaults:
  - Stimulus: addr 0x1234; SPI SRAM model returns 0xBEEF.
  - Response: `mo_o` stream 0x03,0x12,0x34,0x0000; `rdata_o`=0xBEEF at ack.
  - Ack exactly 163 cycles after accept; `csb_o` low for 162 cycles.
- Write, defaults:
  - Stimulus: addr 0x00FF, data 0xA5C3.
  - Response: model captures 0x02,0x00FF,0xA5C3; `rdata_o` keeps its previous value; `ack_o` pulses once.
- Back-to-back: `req_i` held high across two reads.
  - `csb_o` high for CS_GAP+1=3 cycles between frames.
  - Two acks; second accept in the cycle `busy_o` falls.
- Parameter sweep:
  - Settings: ADDR_W=24, DATA_W=8, CLK_DIV=1, CS_GAP=0. Read addr 0xABCDEF returning 0x5A.
  - Response: N=40, ack at cycle 82; SCLK period 2 cycles.
- Reset mid-SHIFT:
  - Stimulus: assert `reset` at bit 20.
  - Response: `csb_o`=1 and `sclk_o`=0 without waiting for a clock edge; no ack; `rdata_o`=0; next request runs a full correct frame.
- Busy rejection:
  - Stimulus: pulse `req_i` with different addr/we while `busy_o`=1.
  - Response: ignored; in-flight frame unchanged; exactly one ack.
